mscan_ctrl: RTL

MSCAN_CTRL -- requirements
Module: mscan_ctrl

---
 rtl/mscan_pkg.sv | 27 ++
 rtl/mscan_rot.sv | 29 ++
 rtl/mscan_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/mscan_pkg.sv
// Shared definitions for the multiplexed-display scan controller:
// state encoding, digit count and one-hot digit constants.
package mscan_pkg;
  localparam int NDIG = 4;
  localparam int IW   = $clog2(NDIG);

  typedef enum logic [1:0] {IDLE = 2'd0, BLANK = 2'd1, SHOW = 2'd2} state_t;

  localparam logic [NDIG-1:0] DIG0 = 4'b0001;
  localparam logic [NDIG-1:0] DIG1 = 4'b0010;
  localparam logic [NDIG-1:0] DIG2 = 4'b0100;
  localparam logic [NDIG-1:0] DIG3 = 4'b1000;

  // Lowest set mask bit as one-hot; DIG0 for an empty mask keeps oh one-hot.
  function automatic logic [NDIG-1:0] lowest_dig(input logic [NDIG-1:0] m);
    logic found;
    lowest_dig = DIG0;
    found      = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (m[i] && !found) begin
        lowest_dig    = '0;
        lowest_dig[i] = 1'b1;
        found         = 1'b1;
      end
    end
  endfunction
endpackage

// File: rtl/mscan_rot.sv
// Next-digit search: rotate above the current one-hot index and take the first
// set mask bit; wrap flags a new index at or below the current one.
module mscan_rot
  import mscan_pkg::*;
(
  input  logic [NDIG-1:0] cur,
  input  logic [NDIG-1:0] mask,
  output logic [NDIG-1:0] nxt,
  output logic            wrap
);
  logic [IW-1:0] cur_idx, nxt_idx, j;

  always_comb begin
    cur_idx = '0;
    j       = '0;
    for (int i = 0; i < NDIG; i++)
      if (cur[i]) cur_idx = IW'(i);
    nxt_idx = cur_idx;
    // Walk distances high to low so the nearest set bit above wins; distance
    // NDIG lands back on the current digit (single-bit mask case).
    for (int k = NDIG; k >= 1; k--) begin
      j = cur_idx + IW'(k);
      if (mask[j]) nxt_idx = j;
    end
    nxt          = '0;
    nxt[nxt_idx] = 1'b1;
    wrap         = (mask != '0) && (nxt_idx <= cur_idx);
  end
endmodule

// File: rtl/mscan_ctrl.sv
// Multiplexed 4-digit display scan controller: BLANK (mux load + dead time)
// then SHOW per digit. Macro SCAN_BLANK_EN enables BLANK_CYC dead time.
module mscan_ctrl
  import mscan_pkg::*;
#(
  parameter int PRESCALE  = 50000,
  parameter int BLANK_CYC = 16
)(
  input  logic            iclk,
  input  logic            ireset,
  input  logic            ien,
  input  logic [NDIG-1:0] idigit_mask,
  output logic [NDIG-1:0] oh,
  output logic            ocle,
  output logic [NDIG-1:0] oan,
  output logic            ofrm
);
  localparam int CW = $clog2(PRESCALE);
`ifdef SCAN_BLANK_EN
  localparam int BLEN = BLANK_CYC;
`else
  localparam int BLEN = 1;
`endif
  localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLEN - 1);

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [NDIG-1:0] oh_nx, oan_nx, rot_nxt;
  logic            ocle_nx, ofrm_nx, rot_wrap, go;

  mscan_rot u_rot (.cur(oh), .mask(idigit_mask), .nxt(rot_nxt), .wrap(rot_wrap));

  assign go = ien && (idigit_mask != '0);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    oh_nx    = oh;
    oan_nx   = oan;
    ocle_nx  = 1'b0;
    ofrm_nx  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        oan_nx = '1;
        if (go) begin
          state_nx = BLANK;
          oh_nx    = lowest_dig(idigit_mask);
          ocle_nx  = 1'b1;
        end
      end
      BLANK: begin
        if (!go) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          oan_nx   = '1;
        end else if (cnt == BLANK_LAST) begin
          state_nx = SHOW;
          cnt_nx   = '0;
          oan_nx   = ~oh;
        end
      end
      SHOW: begin
        // Abort is checked first so it beats a coincident advance.
        if (!go) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          oan_nx   = '1;
        end else if (cnt == SHOW_LAST) begin
          state_nx = BLANK;
          cnt_nx   = '0;
          oh_nx    = rot_nxt;
          oan_nx   = '1;
          ocle_nx  = 1'b1;
          ofrm_nx  = rot_wrap;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        oan_nx   = '1;
      end
    endcase
  end

  always_ff @(posedge iclk) begin
    if (!ireset) begin
      state <= IDLE;
      cnt   <= '0;
      oh    <= DIG0;
      oan   <= '1;
      ocle  <= 1'b0;
      ofrm  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      oh    <= oh_nx;
      oan   <= oan_nx;
      ocle  <= ocle_nx;
      ofrm  <= ofrm_nx;
    end
  end
endmodule
